// File: rtl/thermo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | thermo_pkg : shared encodings for the thermometer count link         |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package thermo_pkg;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_TRACK   = 2'd1,
    ST_ERROR   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_JUMP = 2'b11
  } dir_t;

  localparam int LOCK_COUNT = 3;

endpackage
`default_nettype wire

// File: rtl/thermo_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | thermo_check : combinational thermometer decode with bubble/range chk|
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module thermo_check #(
  parameter int THERMO_W = 16,
  parameter int MOD_N    = 10
) (
  input  logic [THERMO_W-1:0] code,
  output logic [3:0]          k,
  output logic                bubble_err,
  output logic                range_err
);

  localparam int CW = $clog2(THERMO_W + 1);

  logic [CW-1:0]       ones;
  logic [THERMO_W-1:0] mask;

  // A legal code is exactly the contiguous fill implied by its own popcount.
  always_comb begin
    ones = '0;
    for (int i = 0; i < THERMO_W; i++) begin
      ones = ones + CW'(code[i]);
    end
    mask = '0;
    for (int i = 0; i < THERMO_W; i++) begin
      mask[i] = (CW'(i) < ones);
    end
    bubble_err = (code != mask) || (int'(ones) > 15);
    range_err  = !bubble_err && (int'(ones) >= MOD_N);
    k          = 4'(ones);
  end

endmodule
`default_nettype wire

// File: rtl/thermo_count_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | thermo_count_decoder : 2-stage thermometer decode, step class, lock  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module thermo_count_decoder
  import thermo_pkg::*;
#(
  parameter int MOD_N     = 10,
  parameter int THERMO_W  = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [THERMO_W-1:0]  thermo_in,
  input  logic                 err_clr,
  output logic [3:0]           count_out,
  output logic                 count_valid,
  output logic                 code_err,
  output logic [1:0]           dir,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [3:0] TOP_VAL  = 4'(MOD_N - 1);
  localparam logic [1:0] LOCK_VAL = 2'(LOCK_COUNT);

  logic [THERMO_W-1:0] s1_code;
  logic                s1_vld;
  logic                s1_clr;

  logic [3:0] k;
  logic       bubble_err;
  logic       range_err;
  logic       sample_ok;
  logic       sample_bad;
  logic [3:0] up_val;
  logic [3:0] down_val;
  dir_t       step_dir;
  logic [1:0] acq_consec;

  state_t     state;
  logic [1:0] consec;
  logic       have_ref;

  thermo_check #(
    .THERMO_W (THERMO_W),
    .MOD_N    (MOD_N)
  ) u_check (
    .code       (s1_code),
    .k          (k),
    .bubble_err (bubble_err),
    .range_err  (range_err)
  );

  assign sample_ok  = s1_vld && !bubble_err && !range_err;
  assign sample_bad = s1_vld && (bubble_err || range_err);
  assign up_val     = (count_out == TOP_VAL) ? 4'd0 : count_out + 4'd1;
  assign down_val   = (count_out == 4'd0) ? TOP_VAL : count_out - 4'd1;

  // Hold is tested first, then up, so up wins over down when MOD_N=2.
  always_comb begin
    step_dir = DIR_JUMP;
    if (!have_ref || k == count_out) begin
      step_dir = DIR_HOLD;
    end else if (k == up_val) begin
      step_dir = DIR_UP;
    end else if (k == down_val) begin
      step_dir = DIR_DOWN;
    end
    acq_consec = (step_dir == DIR_JUMP) ? 2'd1 : consec + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_code <= '0;
      s1_vld  <= 1'b0;
      s1_clr  <= 1'b0;
    end else begin
      s1_vld  <= clk_en;
      s1_clr  <= err_clr;
      if (clk_en) begin
        s1_code <= thermo_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out   <= 4'd0;
      count_valid <= 1'b0;
      code_err    <= 1'b0;
      dir         <= DIR_HOLD;
      locked      <= 1'b0;
      state       <= ST_ACQUIRE;
      consec      <= 2'd0;
      have_ref    <= 1'b0;
    end else begin
      count_valid <= sample_ok;
      code_err    <= sample_bad;
      if (sample_ok) begin
        count_out <= k;
        dir       <= step_dir;
        have_ref  <= 1'b1;
        case (state)
          ST_ACQUIRE: begin
            consec <= acq_consec;
            if (acq_consec == LOCK_VAL) begin
              state  <= ST_TRACK;
              locked <= 1'b1;
            end
          end
          ST_TRACK: begin
            state <= ST_TRACK;
          end
          ST_ERROR: begin
            state  <= ST_ACQUIRE;
            consec <= 2'd1;
          end
          default: begin
            state  <= ST_ACQUIRE;
            consec <= 2'd0;
            locked <= 1'b0;
          end
        endcase
      end else if (sample_bad) begin
        state    <= ST_ERROR;
        locked   <= 1'b0;
        have_ref <= 1'b0;
        consec   <= 2'd0;
      end
    end
  end

  // The clear rides in stage 1 with its sample so a coincident error still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (s1_clr) begin
      err_cnt <= sample_bad ? ERR_CNT_W'(1) : '0;
    end else if (sample_bad && !(&err_cnt)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_thermo_count_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_thermo_count_decoder : scoreboard bench for thermo_count_decoder  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_thermo_count_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b0;
  logic [15:0] thermo_in = 16'h0;
  logic        err_clr = 1'b0;
  logic [3:0]  count_out;
  logic        count_valid;
  logic        code_err;
  logic [1:0]  dir;
  logic        locked;
  logic [7:0]  err_cnt;

  thermo_count_decoder #(
    .MOD_N     (10),
    .THERMO_W  (16),
    .ERR_CNT_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .thermo_in   (thermo_in),
    .err_clr     (err_clr),
    .count_out   (count_out),
    .count_valid (count_valid),
    .code_err    (code_err),
    .dir         (dir),
    .locked      (locked),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int vld;
    int err;
    int dr;
    int lck;
    int ecnt;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  int m_count, m_dir, m_locked, m_err, m_state, m_consec;
  bit m_ref;

  task automatic check(input string tag, input int obs, input int want);
    total++;
    if (obs != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_dir = 0; m_locked = 0; m_err = 0;
    m_state = 0; m_consec = 0; m_ref = 0;
  endtask

  task automatic push_exp(input int v, input int e);
    exp_t x;
    x.cnt = m_count; x.vld = v; x.err = e; x.dr = m_dir;
    x.lck = m_locked; x.ecnt = m_err;
    sbq.push_back(x);
  endtask

  // Independent reference: state 0=acquire, 1=track, 2=error.
  task automatic model_apply(input logic en, input logic [15:0] code, input logic clr);
    int kk;
    int d;
    bit ok;
    logic [15:0] pat;
    kk = -1;
    for (int i = 0; i < 16; i++) begin
      pat = 16'((32'd1 << i) - 1);
      if (code == pat) kk = i;
    end
    ok = (kk >= 0) && (kk < 10);
    if (clr) m_err = (en && !ok) ? 1 : 0;
    else if (en && !ok && m_err < 255) m_err++;
    if (!en) begin
      push_exp(0, 0);
    end else if (!ok) begin
      m_state = 2; m_locked = 0; m_ref = 0; m_consec = 0;
      push_exp(0, 1);
    end else begin
      if (!m_ref || kk == m_count) d = 0;
      else if (kk == (m_count + 1) % 10) d = 1;
      else if (kk == (m_count + 9) % 10) d = 2;
      else d = 3;
      if (m_state == 2) begin
        m_state = 0; m_consec = 1;
      end else if (m_state == 0) begin
        m_consec = (d == 3) ? 1 : m_consec + 1;
        if (m_consec >= 3) begin
          m_state = 1; m_locked = 1;
        end
      end
      m_ref = 1; m_count = kk; m_dir = d;
      push_exp(1, 0);
    end
  endtask

  task automatic step(input logic en, input logic [15:0] code, input logic clr);
    exp_t x;
    clk_en = en; thermo_in = code; err_clr = clr;
    model_apply(en, code, clr);
    @(posedge clk);
    #1;
    if (sbq.size() >= 2) begin
      x = sbq.pop_front();
      check("count_out", int'(count_out), x.cnt);
      check("count_valid", int'(count_valid), x.vld);
      check("code_err", int'(code_err), x.err);
      check("dir", int'(dir), x.dr);
      check("locked", int'(locked), x.lck);
      check("err_cnt", int'(err_cnt), x.ecnt);
    end
  endtask

  task automatic strobe(input logic [15:0] code);
    step(1'b1, code, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0);
  endtask

  // Asserted off-edge; outputs must clear before any clock arrives.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    clk_en = 1'b0; err_clr = 1'b0;
    #1;
    check("rst_count_out", int'(count_out), 0);
    check("rst_count_valid", int'(count_valid), 0);
    check("rst_code_err", int'(code_err), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    model_reset();
    sbq.delete();
    push_exp(0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    for (int i = 0; i < 10; i++) strobe(16'((32'd1 << i) - 1));
    strobe(16'h0000);
    idle(3);

    strobe(16'h01FF);
    strobe(16'h00FF);

    strobe(16'h007F); strobe(16'h003F); strobe(16'h001F);
    strobe(16'h000F); strobe(16'h0007);
    strobe(16'h0005);
    idle(1);
    strobe(16'h000F);

    strobe(16'h03FF);
    strobe(16'hFFFF);
    idle(2);

    strobe(16'h0001); strobe(16'h001F); strobe(16'h003F); strobe(16'h007F);

    strobe(16'h0001); strobe(16'h0003); strobe(16'h0007);
    strobe(16'h007F);
    idle(1);

    for (int i = 0; i < 300; i++) strobe((i % 2 == 0) ? 16'h0005 : 16'h0400);
    step(1'b1, 16'h0009, 1'b1);
    idle(1);
    step(1'b0, 16'h0, 1'b1);
    strobe(16'h0002);

    strobe(16'h0003);
    strobe(16'h0007);
    do_reset();
    strobe(16'h001F);
    strobe(16'h003F);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
